vga_pixel_scanner: RTL and testbench
====================================

Name: vga_pixel_scanner

Overview:
- Downstream consumer of the 1-bpp pixel frame memory (640x240 bits, 2-pixel reads).
- Generates 640x480@60 VGA timing and issues read addresses {row, pair} to the memory.
- Line-doubles each stored row, serialises each returned 2-bit pair into two screen pixels and drives registered RGB/sync to the DAC.

Parameters:
- N, 32, memory address/data width; address = {j[N-1:N/2], i[N/2-1:0]}.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800).
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525).
- CLK_DIV, 2, clk cycles per pixel tick (1..4).
- FG_COLOR, 24'hFFFFFF, RGB for stored bit 1.
- BG_COLOR, 24'h000000, RGB for stored bit 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_address  out  N  {j = v/2, i = h/2} to pixel memory.
- mem_enable  out  1  memory write enable; tied 0 (read-only consumer).
- mem_data  in  N  memory read data; only bits [1:0] used, bit0 = even pixel, bit1 = odd pixel.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  high while RGB is in the visible area.
- rgb  out  24  pixel colour {R,G,B}.
- frame_start  out  1  one-tick pulse aligned with output pixel (0,0).

Behaviour:
- Divider: counter 0..CLK_DIV-1; pixel tick `tick` when count==CLK_DIV-1. CLK_DIV=1 gives tick every cycle. All pipeline stages advance only on tick.
- Counters: h in 0..799, v in 0..524.
  - On tick, h increments; h wraps 799->0 and v increments on that wrap.
  - v wraps 524->0 on the same tick as h wraps.
- Stage A (tick edge t): mem_address <= {v[9:1], h[9:1]} zero-extended, only when h<640 and v<480; otherwise holds the last value.
  - Address is stable for 2*CLK_DIV cycles.
  - The memory samples it on the next rising edge with enable low.
- Stage B (tick t+1): capture sel = h[0] and the visible/sync flags into the delay pipe.
- Stage C (tick t+2): bit = mem_data[sel].
  - rgb <= visible ? (bit ? FG_COLOR : BG_COLOR) : 0.
  - hsync, vsync, video_on and frame_start are registered from the 2-tick delayed counter flags.
- Latency: counter state to pin outputs = exactly 2 ticks; RGB and syncs are always mutually aligned.
- hsync low when H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC. vsync is defined likewise on v.
- frame_start = 1 for one tick when the delayed (h,v)==(0,0).
- Blanking: rgb forced 0 whenever video_on=0, regardless of mem_data.
- Row mapping: lines 2k and 2k+1 both read row k; v=479 reads row 239; j never exceeds 239 and i never exceeds 319.
- Reset (any cycle, including mid-line):
  - h=v=0, divider=0, delay pipe cleared.
  - mem_address=0, rgb=0, video_on=0, hsync=vsync=1, frame_start=0.
  - First tick after reset release starts a fresh frame; frame_start fires 2 ticks later.
- mem_enable is constant 0 in and out of reset.

Optional Feature:
- Macro VGA_SCAN_BORDER_EN.
- Defined: visible pixels with h==0, h==639, v==0 or v==479 output FG_COLOR, overriding memory (alignment/monitor test aid). Pipeline latency is unchanged.
- Undefined: no border logic; all visible pixels come from memory.

Decomposition:
- Shared package vga_pkg:
  - localparams H_TOTAL=800, V_TOTAL=525, sync start/end derived constants.
  - typedef rgb_t (logic [23:0]).
  - typedef struct scan_flags_t {visible, hs, vs, sof, sel}, used for the delay pipe.
- Sub-module vga_timing_gen: divider, h/v counters, sync/visible flag generation.
- vga_pixel_scanner: address stage, delay pipe and colour mux.

Test Plan:
- Reset, then run 1 frame with memory all 0 -> hsync period 800 ticks with 96-tick low pulse starting at h=656; vsync low for lines 490-491; 525 lines per frame; rgb=0 throughout.
- Memory row 0 = 640'b01 repeating -> lines 0 and 1 output alternating BG,FG starting with FG at x=0; mem_address j=0 for both lines, i steps 0..319.
- Single bit set at mem[239][639] -> FG appears only at (639,478) and (639,479), exactly 2 ticks after those counter values.
- CLK_DIV=2 -> each rgb value is held 2 clk; mem_address changes every 4 clk; mem_enable never asserts.
- Assert rst at h=300,v=100 for 3 cycles -> outputs take reset values next edge; after release frame_start pulses once, 2 ticks later, and exactly every 420000 ticks thereafter.
- With VGA_SCAN_BORDER_EN and memory all 0 -> FG on the four edge lines only; without the macro -> all BG.

Source files
------------

// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA pixel scanner slice.
//   - Default 640x480@60 timing constants and the derived totals and sync
//     window bounds.
//   - rgb_t: 24-bit {R,G,B} colour word.
//   - scan_flags_t: per-pixel control bits carried down the delay pipe.
//   - pixel_color(): the final colour mux, shared by the top level.
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
    localparam int V_TOTAL      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525
    localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;                          // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;                     // 752
    localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;                          // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;                     // 492

    // Width of the h/v counters; totals up to 1024 fit.
    localparam int CNT_W = 10;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic visible;  // pixel lies in the active area
        logic hs;       // inside the horizontal sync pulse (active-high here)
        logic vs;       // inside the vertical sync pulse (active-high here)
        logic sof;      // first pixel of the frame, (h,v) == (0,0)
        logic sel;      // which half of the 2-pixel memory word: h[0]
    } scan_flags_t;

    localparam scan_flags_t FLAGS_IDLE = '0;

    // Blanked pixels are always black; visible pixels pick FG or BG.
    function automatic rgb_t pixel_color(input logic visible,
                                         input logic force_fg,
                                         input logic bit_on,
                                         input rgb_t fg,
                                         input rgb_t bg);
        rgb_t c;
        c = '0;
        if (visible) begin
            c = (force_fg || bit_on) ? fg : bg;
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-tick divider plus horizontal/vertical scan counters for the VGA
//   scanner. Flags are combinational decodes of the current counter state;
//   the caller registers them on tick.
//
//   Ports
//     clk      in   system clock, rising edge
//     rst      in   synchronous active-high reset (divider and counters to 0)
//     tick     out  one-cycle pixel strobe, every CLK_DIV clocks
//     h        out  horizontal position 0..H_TOTAL-1
//     v        out  vertical position 0..V_TOTAL-1
//     visible  out  (h,v) lies in the active area
//     hs       out  h inside the sync pulse (active-high)
//     vs       out  v inside the sync pulse (active-high)
//     sof      out  (h,v) == (0,0)
//
//   Totals must fit in vga_pkg::CNT_W bits; CLK_DIV must be 1..4.
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS   = H_VIS_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_VIS   = V_VIS_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             visible,
    output logic             hs,
    output logic             vs,
    output logic             sof
);

    localparam logic [1:0]       DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic [1:0]       div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             tick_c;

    // With CLK_DIV == 1 DIV_LAST is 0, so the divider sits at 0 and every
    // cycle is a tick.
    always_comb begin
        div_d  = div_q;
        h_d    = h_q;
        v_d    = v_q;
        tick_c = (div_q == DIV_LAST);
        if (tick_c) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign tick    = tick_c;
    assign h       = h_q;
    assign v       = v_q;
    assign visible = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs      = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs      = (v_q >= VS_BEG) && (v_q < VS_END);
    assign sof     = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_pixel_scanner.sv
// ----------------------------------------------------------------------------
// vga_pixel_scanner
//   Reads a 1-bpp frame memory (2 pixels per word, half vertical resolution)
//   and drives line-doubled VGA video with registered RGB and syncs.
//
//   Ports
//     clk          in   system clock, rising edge
//     rst          in   synchronous active-high reset
//     mem_address  out  {j = v/2 in upper half, i = h/2 in lower half}
//     mem_enable   out  memory write enable, constant 0 (read-only client)
//     mem_data     in   read data; bit0 = even pixel, bit1 = odd pixel
//     hsync        out  horizontal sync, active low
//     vsync        out  vertical sync, active low
//     video_on     out  rgb carries active-area pixels
//     rgb          out  {R,G,B}
//     frame_start  out  one-tick pulse with output pixel (0,0)
//
//   Pipeline (all stages advance on the pixel tick): counter state sampled at
//   tick t issues the address and enters p0, moves to p1 at t+1 and reaches
//   the pins at t+2.
//
//   Build option: define VGA_SCAN_BORDER_EN to force FG_COLOR on the
//   outermost visible rows/columns, independent of memory contents.
// ----------------------------------------------------------------------------
module vga_pixel_scanner
    import vga_pkg::*;
#(
    parameter int   N        = 32,
    parameter int   H_VIS    = H_VIS_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_VIS    = V_VIS_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter int   CLK_DIV  = 2,
    parameter rgb_t FG_COLOR = 24'hFFFFFF,
    parameter rgb_t BG_COLOR = 24'h000000
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] mem_address,
    output logic         mem_enable,
    input  logic [N-1:0] mem_data,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic [23:0]  rgb,
    output logic         frame_start
);

    localparam int HALF = N / 2;

    logic             tick;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             visible;
    logic             hs;
    logic             vs;
    logic             sof;

    vga_timing_gen #(
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP),
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .h       (h),
        .v       (v),
        .visible (visible),
        .hs      (hs),
        .vs      (vs),
        .sof     (sof)
    );

    logic [N-1:0] mem_address_q, mem_address_d;
    scan_flags_t  flags_p0_q, flags_p0_d;
    scan_flags_t  flags_p1_q, flags_p1_d;
    logic [1:0]   pair_p1_q, pair_p1_d;
    rgb_t         rgb_q, rgb_d;
    logic         hsync_q, hsync_d;
    logic         vsync_q, vsync_d;
    logic         video_on_q, video_on_d;
    logic         frame_start_q, frame_start_d;
    logic [1:0]   pair_src;
    logic         bit_on;
    logic         border_p1;

`ifdef VGA_SCAN_BORDER_EN
    logic border_p0_q, border_p0_d;
    logic border_p1_q, border_p1_d;

    always_comb begin
        border_p0_d = border_p0_q;
        border_p1_d = border_p1_q;
        if (tick) begin
            border_p0_d = (h == '0) || (h == CNT_W'(H_VIS - 1)) ||
                          (v == '0) || (v == CNT_W'(V_VIS - 1));
            border_p1_d = border_p0_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            border_p0_q <= 1'b0;
            border_p1_q <= 1'b0;
        end else begin
            border_p0_q <= border_p0_d;
            border_p1_q <= border_p1_d;
        end
    end

    assign border_p1 = border_p1_q;
`else
    assign border_p1 = 1'b0;
`endif

    always_comb begin
        mem_address_d = mem_address_q;
        flags_p0_d    = flags_p0_q;
        flags_p1_d    = flags_p1_q;
        pair_p1_d     = pair_p1_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        frame_start_d = frame_start_q;

        // The memory answers one clock after it samples the address. With
        // CLK_DIV == 1 that answer lands exactly on tick t+2, so it is used
        // straight from the pins. With slower ticks the address may already
        // have moved on to the next pair by t+2, so the word is latched at
        // t+1 while it is still the one requested at t.
        pair_src = (CLK_DIV == 1) ? mem_data[1:0] : pair_p1_q;
        bit_on   = pair_src[flags_p1_q.sel];

        if (tick) begin
            // ---- p0: address issue and flag capture (tick t) ----
            // Outside the active area the last address is held, so the
            // memory never sees a row/column beyond the stored image.
            if (visible) begin
                mem_address_d = {HALF'(v[CNT_W-1:1]), HALF'(h[CNT_W-1:1])};
            end
            flags_p0_d.visible = visible;
            flags_p0_d.hs      = hs;
            flags_p0_d.vs      = vs;
            flags_p0_d.sof     = sof;
            flags_p0_d.sel     = h[0];

            // ---- p1: delay pipe and memory word capture (tick t+1) ----
            flags_p1_d = flags_p0_q;
            pair_p1_d  = mem_data[1:0];

            // ---- output registers (tick t+2) ----
            rgb_d         = pixel_color(flags_p1_q.visible, border_p1, bit_on,
                                        FG_COLOR, BG_COLOR);
            hsync_d       = ~flags_p1_q.hs;
            vsync_d       = ~flags_p1_q.vs;
            video_on_d    = flags_p1_q.visible;
            frame_start_d = flags_p1_q.sof;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_address_q <= '0;
            flags_p0_q    <= FLAGS_IDLE;
            flags_p1_q    <= FLAGS_IDLE;
            pair_p1_q     <= '0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            mem_address_q <= mem_address_d;
            flags_p0_q    <= flags_p0_d;
            flags_p1_q    <= flags_p1_d;
            pair_p1_q     <= pair_p1_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mem_address = mem_address_q;
    assign mem_enable  = 1'b0;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

    // Only the low pixel pair of each word is meaningful, and line doubling
    // discards v[0] from the address.
    logic unused_ok;
    assign unused_ok = ^{mem_data[N-1:2], v[0]};

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// ----------------------------------------------------------------------------
// tb_vga_pixel_scanner
//   Drives the scanner with a reduced screen geometry and a behavioural frame
//   memory. Expected outputs come from a position model: after n pixel ticks
//   since reset release, the pins show screen position (n-3) mod frame size,
//   and the address shows the last visible position reached.
// ----------------------------------------------------------------------------
module tb_vga_pixel_scanner;

    localparam int N       = 32;
    localparam int H_VIS   = 16;
    localparam int H_FP    = 2;
    localparam int H_SYNC  = 3;
    localparam int H_BP    = 3;
    localparam int V_VIS   = 8;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 2;
    localparam int CLK_DIV = 2;
    localparam int HT      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME   = HT * VT;
    localparam logic [23:0] FG = 24'hA5C3E1;
    localparam logic [23:0] BG = 24'h102030;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  mem_address;
    logic          mem_enable;
    logic [N-1:0]  mem_data = '0;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [23:0]   rgb;
    logic          frame_start;

    always #5 clk = ~clk;

    vga_pixel_scanner #(
        .N        (N),
        .H_VIS    (H_VIS),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_VIS    (V_VIS),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV),
        .FG_COLOR (FG),
        .BG_COLOR (BG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_address (mem_address),
        .mem_enable  (mem_enable),
        .mem_data    (mem_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    // Stored image: V_VIS/2 rows of H_VIS pixels.
    bit pix [0:V_VIS/2-1][0:H_VIS-1];

    // Frame memory: synchronous read, one clock of latency, junk upper bits.
    logic [15:0] rd_j;
    logic [15:0] rd_i;
    assign rd_j = mem_address[31:16];
    assign rd_i = mem_address[15:0];

    always @(posedge clk) begin
        if (rd_j < V_VIS/2 && rd_i < H_VIS/2)
            mem_data <= {30'($urandom), pix[rd_j][2*rd_i+1], pix[rd_j][2*rd_i]};
        else
            mem_data <= {30'($urandom), 2'b00};
    end

    int compared = 0;
    int mismatched = 0;
    int c = -1;              // clock edges since reset release
    int cyc = 0;             // absolute clock edge count
    int last_fs = -1;        // cycle of the previous frame_start rise
    logic fs_prev = 1'b0;
    logic [31:0] exp_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int h, input int v);
        if (!(h < H_VIS && v < V_VIS)) return 24'h0;
`ifdef VGA_SCAN_BORDER_EN
        if (h == 0 || h == H_VIS-1 || v == 0 || v == V_VIS-1) return FG;
`endif
        return pix[v/2][h] ? FG : BG;
    endfunction

    // One clock edge, model update, then compare every output.
    task automatic step();
        int k, p, h, v, nt;
        @(posedge clk);
        cyc++;
        if (rst) begin
            c        = -1;
            exp_addr = '0;
            last_fs  = -1;
        end else begin
            c++;
            if ((c + 1) % CLK_DIV == 0) begin
                k = (c + 1) / CLK_DIV - 1;
                p = k % FRAME;
                h = p % HT;
                v = p / HT;
                if (h < H_VIS && v < V_VIS) exp_addr = 32'((v / 2) * 65536 + h / 2);
            end
        end
        #1;
        nt = (c < 0) ? 0 : (c + 1) / CLK_DIV;
        chk("mem_address", mem_address, exp_addr);
        chk("mem_enable", 32'(mem_enable), 32'd0);
        if (nt < 3) begin
            chk("hsync_idle", 32'(hsync), 32'd1);
            chk("vsync_idle", 32'(vsync), 32'd1);
            chk("video_on_idle", 32'(video_on), 32'd0);
            chk("rgb_idle", 32'(rgb), 32'd0);
            chk("frame_start_idle", 32'(frame_start), 32'd0);
        end else begin
            p = (nt - 3) % FRAME;
            h = p % HT;
            v = p / HT;
            chk("hsync", 32'(hsync), 32'(!(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC)));
            chk("vsync", 32'(vsync), 32'(!(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC)));
            chk("video_on", 32'(video_on), 32'(h < H_VIS && v < V_VIS));
            chk("rgb", 32'(rgb), 32'(exp_rgb(h, v)));
            chk("frame_start", 32'(frame_start), 32'(p == 0));
        end
        if (frame_start === 1'b1 && fs_prev === 1'b0) begin
            if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(FRAME * CLK_DIV));
            last_fs = cyc;
        end
        fs_prev = frame_start;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int j = 0; j < V_VIS/2; j++)
            for (int i = 0; i < H_VIS; i++)
                pix[j][i] = (mode == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
    endtask

    initial begin
        // Blank memory: timing, syncs and BG-only picture.
        fill(0);
        do_reset(3);
        run(FRAME * CLK_DIV + 40);

        // Row 0 alternating, FG on even pixels.
        do_reset(2);
        fill(0);
        for (int i = 0; i < H_VIS; i += 2) pix[0][i] = 1'b1;
        rst = 1'b0;
        run(FRAME * CLK_DIV + 10);

        // Single bit in the last stored row/column.
        do_reset(2);
        fill(0);
        pix[V_VIS/2-1][H_VIS-1] = 1'b1;
        run(FRAME * CLK_DIV + 10);

        // Random image over two frames, then a reset partway through a line.
        do_reset(2);
        fill(1);
        run(2 * FRAME * CLK_DIV + CLK_DIV * (3 * HT + 6));
        do_reset(3);
        fill(1);
        run(3 * FRAME * CLK_DIV + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
